ice_gpio_bank: RTL and testbench



---
 rtl/ice_gpio_pkg.sv | 22 ++
 rtl/ice_gpio_bank_if.sv | 30 +++
 rtl/ice_rst_seq.sv | 75 +++++++
 rtl/ice_gpio_bank.sv | 110 +++++++++++
 tb/tb_ice_gpio_bank.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ice_gpio_pkg.sv
// Shared constants for the pico-ice GPIO bank: register map and the
// core-reset sequencer state encoding.
package ice_gpio_pkg;

  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_OUT     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OE      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IN      = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_RISE    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_FALL    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_SET_OUT = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_CLR_OUT = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_TGL_OUT = 3'd7;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } rst_state_e;

endpackage

// File: rtl/ice_gpio_bank_if.sv
// Request/response register port of the GPIO bank.
interface ice_gpio_bank_if #(
  parameter int N_PINS = 26
) ();
  import ice_gpio_pkg::*;

  // A request transfers on a clock edge where req_valid && req_ready; the
  // master holds req_* stable while req_valid is high and not yet accepted.
  // A response transfers on an edge where rsp_valid && rsp_ready; the slave
  // holds rsp_valid/rsp_rdata stable until then.
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [N_PINS-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N_PINS-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ice_rst_seq.sv
// Core reset sequencer: releases core_rst_n only after the synchronised PLL
// lock has been seen high for LOCK_HOLD consecutive cycles.
module ice_rst_seq
  import ice_gpio_pkg::*;
#(
  parameter int LOCK_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  output logic       core_rst_n_o,
  output rst_state_e state_o
);

  localparam int CNT_W = $clog2(LOCK_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LOCK_HOLD - 1);

  logic [1:0]       lock_sync_q;
  logic             lock_s;
  rst_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign lock_s = lock_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync_q <= '0;
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[0], pll_locked_i};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  // cnt_q counts lock samples seen so far, including the one that left WAIT_LOCK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lock_s) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q >= HOLD_LAST) begin
          state_d = RUN;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  assign core_rst_n_o = (state_q == RUN);
  assign state_o      = state_q;

endmodule

// File: rtl/ice_gpio_bank.sv
// N-channel pad bank for pico-ice: output/enable registers, synchronised
// inputs with sticky edge flags behind a register port, plus core reset sequencing.
module ice_gpio_bank
  import ice_gpio_pkg::*;
#(
  parameter int N_PINS      = 26,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_HOLD   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked,
  output logic              core_rst_n,
  input  logic [N_PINS-1:0] pad_i,
  output logic [N_PINS-1:0] pad_o,
  output logic [N_PINS-1:0] pad_oe,
  ice_gpio_bank_if.slave    bus,
  output rst_state_e        seq_state_o
);

  logic [N_PINS-1:0] sync_q [SYNC_STAGES];
  logic [N_PINS-1:0] sync_in, prev_q, rise_edge, fall_edge;
  logic [N_PINS-1:0] out_q, out_d, oe_q, oe_d;
  logic [N_PINS-1:0] rise_q, rise_d, fall_q, fall_d, rise_clr, fall_clr;
  logic [N_PINS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              accept;

  ice_rst_seq #(.LOCK_HOLD(LOCK_HOLD)) u_rst_seq (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked_i (pll_locked),
    .core_rst_n_o (core_rst_n),
    .state_o      (seq_state_o)
  );

  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign rise_edge = sync_in & ~prev_q;
  assign fall_edge = ~sync_in & prev_q;
  assign accept    = bus.req_valid && !rsp_valid_q;

  always_comb begin
    out_d       = out_q;
    oe_d        = oe_q;
    rise_clr    = '0;
    fall_clr    = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      if (!bus.req_write) begin
        unique case (bus.req_addr)
          ADDR_OUT:  rsp_rdata_d = out_q;
          ADDR_OE:   rsp_rdata_d = oe_q;
          ADDR_IN:   rsp_rdata_d = sync_in;
          ADDR_RISE: rsp_rdata_d = rise_q;
          ADDR_FALL: rsp_rdata_d = fall_q;
          default:   rsp_rdata_d = '0;
        endcase
      end else begin
        unique case (bus.req_addr)
          ADDR_OUT:     out_d    = bus.req_wdata;
          ADDR_OE:      oe_d     = bus.req_wdata;
          ADDR_RISE:    rise_clr = bus.req_wdata;
          ADDR_FALL:    fall_clr = bus.req_wdata;
          ADDR_SET_OUT: out_d    = out_q | bus.req_wdata;
          ADDR_CLR_OUT: out_d    = out_q & ~bus.req_wdata;
          ADDR_TGL_OUT: out_d    = out_q ^ bus.req_wdata;
          default:      out_d    = out_q;
        endcase
      end
    end else if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    // A fresh edge on the same bit as a write-1-to-clear keeps the flag set.
    rise_d = (rise_q & ~rise_clr) | rise_edge;
    fall_d = (fall_q & ~fall_clr) | fall_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q      <= '0;
      out_q       <= '0;
      oe_q        <= '0;
      rise_q      <= '0;
      fall_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      sync_q[0] <= pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q      <= sync_in;
      out_q       <= out_d;
      oe_q        <= oe_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign pad_o         = out_q;
  assign pad_oe        = oe_q;
  assign bus.req_ready = !rsp_valid_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ice_gpio_bank.sv
// Bench for ice_gpio_bank: directed scenarios plus random traffic, checked
// every cycle against a delay-line/counter model of the bank.
module tb_ice_gpio_bank;
  import ice_gpio_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int LH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pll_locked = 1'b0;
  logic         core_rst_n;
  logic [W-1:0] pad_i = '0;
  logic [W-1:0] pad_o, pad_oe;
  rst_state_e   seq_state;

  ice_gpio_bank_if #(.N_PINS(W)) bus ();

  ice_gpio_bank #(.N_PINS(W), .SYNC_STAGES(SS), .LOCK_HOLD(LH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .core_rst_n  (core_rst_n),
    .pad_i       (pad_i),
    .pad_o       (pad_o),
    .pad_oe      (pad_oe),
    .bus         (bus),
    .seq_state_o (seq_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_out, m_oe, m_rise, m_fall, m_rsp_d;
  bit           m_rsp_v;
  int           hi_run;            // consecutive lock samples seen by the sequencer
  logic [W-1:0] pad_hist[$];       // pad_i samples, oldest first
  bit           lock_hist[$];      // pll_locked samples, oldest first
  logic [W-1:0] exp_q[$];          // expected read data per accepted request
  bit           prev_v;

  task automatic model_reset();
    m_out = '0; m_oe = '0; m_rise = '0; m_fall = '0; m_rsp_d = '0;
    m_rsp_v = 1'b0;
    hi_run = 0;
    pad_hist.delete();
    repeat (SS + 1) pad_hist.push_back('0);
    lock_hist.delete();
    repeat (2) lock_hist.push_back(1'b0);
    exp_q.delete();
    prev_v = 1'b0;
  endtask

  task automatic model_step();
    logic [W-1:0] s_cur, s_prev, re, fe, rd, rm, fm;
    bit acc, comp;
    s_cur  = pad_hist[1];
    s_prev = pad_hist[0];
    re = s_cur & ~s_prev;
    fe = ~s_cur & s_prev;
    acc  = bus.req_valid && !m_rsp_v;
    comp = m_rsp_v && bus.rsp_ready;
    rd = '0; rm = '0; fm = '0;
    if (acc) begin
      if (!bus.req_write) begin
        case (bus.req_addr)
          3'd0: rd = m_out;
          3'd1: rd = m_oe;
          3'd2: rd = s_cur;
          3'd3: rd = m_rise;
          3'd4: rd = m_fall;
          default: rd = '0;
        endcase
      end else begin
        case (bus.req_addr)
          3'd0: m_out = bus.req_wdata;
          3'd1: m_oe  = bus.req_wdata;
          3'd3: rm    = bus.req_wdata;
          3'd4: fm    = bus.req_wdata;
          3'd5: m_out = m_out | bus.req_wdata;
          3'd6: m_out = m_out & ~bus.req_wdata;
          3'd7: m_out = m_out ^ bus.req_wdata;
          default: ;
        endcase
      end
      m_rsp_v = 1'b1;
      m_rsp_d = rd;
      exp_q.push_back(rd);
    end else if (comp) begin
      m_rsp_v = 1'b0;
    end
    m_rise = (m_rise & ~rm) | re;
    m_fall = (m_fall & ~fm) | fe;
    if (lock_hist[0]) begin
      if (hi_run < LH) hi_run++;
    end else begin
      hi_run = 0;
    end
    pad_hist.push_back(pad_i);
    void'(pad_hist.pop_front());
    lock_hist.push_back(pll_locked);
    void'(lock_hist.pop_front());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("core_rst_n", 32'(core_rst_n), 32'(hi_run >= LH));
      check("pad_o", 32'(pad_o), 32'(m_out));
      check("pad_oe", 32'(pad_oe), 32'(m_oe));
      check("req_ready", 32'(bus.req_ready), 32'(!m_rsp_v));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(m_rsp_v));
      if (m_rsp_v) check("rsp_rdata", 32'(bus.rsp_rdata), 32'(m_rsp_d));
      if (bus.rsp_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_txn: response 0x%0h with no accepted request at %0t", bus.rsp_rdata, $time);
        end else begin
          check("rsp_txn", 32'(bus.rsp_rdata), 32'(exp_q.pop_front()));
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input bit wr, input logic [2:0] addr, input logic [W-1:0] wd,
                        output logic [W-1:0] rd);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL req_accept_timeout: req_ready stayed 0 for addr %0d", addr);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rsp_latency", 32'(bus.rsp_valid), 32'd1);
    rd = bus.rsp_rdata;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [W-1:0] rd;
    bit last_ready;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_pad_o", 32'(pad_o), 32'h0);
    check("rst_pad_oe", 32'(pad_oe), 32'h0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'h0);
    check("rst_req_ready", 32'(bus.req_ready), 32'h1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
    check("rst_seq_state", 32'(seq_state), 32'(WAIT_LOCK));
    rst_n = 1'b1;

    // Lock sequence: 2 sync + 4 hold cycles
    repeat (5) @(negedge clk);
    pll_locked = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("lock_release", 32'(core_rst_n), 32'(i == 6));
    end

    // Output ops
    do_req(1'b1, ADDR_OUT, 8'h0F, rd);
    do_req(1'b1, ADDR_OE, 8'hFF, rd);
    do_req(1'b1, ADDR_SET_OUT, 8'h30, rd);
    do_req(1'b1, ADDR_CLR_OUT, 8'h03, rd);
    do_req(1'b1, ADDR_TGL_OUT, 8'h81, rd);
    check("tgl_rsp_is_zero", 32'(rd), 32'h0);
    do_req(1'b0, ADDR_OUT, 8'h00, rd);
    check("out_readback", 32'(rd), 32'hBD);
    check("pad_o_value", 32'(pad_o), 32'hBD);
    check("pad_oe_value", 32'(pad_oe), 32'hFF);
    do_req(1'b0, ADDR_SET_OUT, 8'h00, rd);
    check("set_out_reads_zero", 32'(rd), 32'h0);

    // Loss of lock: core reset after 3 cycles, pads untouched
    @(negedge clk);
    pll_locked = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("lock_drop", 32'(core_rst_n), 32'(i < 3));
    end
    check("pad_o_after_lock_loss", 32'(pad_o), 32'hBD);
    pll_locked = 1'b1;

    // Edge capture
    @(negedge clk);
    pad_i = 8'h05;
    repeat (4) @(negedge clk);
    pad_i = 8'h01;
    repeat (4) @(negedge clk);
    do_req(1'b0, ADDR_RISE, 8'h00, rd);
    check("rise_capture", 32'(rd), 32'h05);
    do_req(1'b0, ADDR_FALL, 8'h00, rd);
    check("fall_capture", 32'(rd), 32'h04);
    do_req(1'b0, ADDR_IN, 8'h00, rd);
    check("in_value", 32'(rd), 32'h01);
    do_req(1'b1, ADDR_IN, 8'hFF, rd);
    do_req(1'b1, ADDR_RISE, 8'h01, rd);
    do_req(1'b0, ADDR_RISE, 8'h00, rd);
    check("rise_w1c", 32'(rd), 32'h04);
    do_req(1'b1, ADDR_RISE, 8'h04, rd);
    do_req(1'b0, ADDR_RISE, 8'h00, rd);
    check("rise_cleared", 32'(rd), 32'h00);

    // W1C race: bit 2 rise reaches the edge logic on the W1C acceptance edge
    @(negedge clk);
    pad_i = 8'h05;
    @(negedge clk);
    do_req(1'b1, ADDR_RISE, 8'h04, rd);
    do_req(1'b0, ADDR_RISE, 8'h00, rd);
    check("w1c_race_set_wins", 32'(rd), 32'h04);

    // Backpressure on a read of IN, with a second request waiting
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = ADDR_IN;
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_addr  = ADDR_OUT;
    bus.req_wdata = 8'h00;
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("bp_in_read", 32'(bus.rsp_rdata), 32'h05);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_hold_ready", 32'(bus.req_ready), 32'h0);
      check("bp_hold_rdata", 32'(bus.rsp_rdata), 32'h05);
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp_done", 32'(bus.rsp_valid), 32'h0);
    check("bp_second_not_taken", 32'(pad_o), 32'hBD);

    // Reset in the middle of an outstanding response
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = ADDR_OUT;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("async_pad_oe", 32'(pad_oe), 32'h0);
    check("async_pad_o", 32'(pad_o), 32'h0);
    check("async_core_rst_n", 32'(core_rst_n), 32'h0);
    pad_i = 8'h00;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, ADDR_RISE, 8'h00, rd);
    check("rise_after_reset", 32'(rd), 32'h00);
    do_req(1'b0, ADDR_FALL, 8'h00, rd);
    check("fall_after_reset", 32'(rd), 32'h00);

    // Random traffic
    last_ready = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (!(bus.req_valid && !last_ready)) begin
        bus.req_valid = ($urandom_range(0, 1) == 1);
        bus.req_write = ($urandom_range(0, 1) == 1);
        bus.req_addr  = 3'($urandom_range(0, 7));
        bus.req_wdata = 8'($urandom);
      end
      last_ready = bus.req_ready;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) pad_i = 8'($urandom);
      if (!pll_locked) begin
        if ($urandom_range(0, 7) == 0) pll_locked = 1'b1;
      end else begin
        if ($urandom_range(0, 59) == 0) pll_locked = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
